int_dispatch_queue: RTL and testbench

Circular FIFO between rename/decode and the integer reservation station. It buffers renamed uops and presents the oldest uop on a valid/ready handshake, the same handshake the RS consumes. While uops wait, it snoops the CDB and sets their source-ready bits, so no wakeup is missed between rename and RS allocation. Flush clears the queue on misprediction.

---
 rtl/int_dispatch_queue.sv | 125 ++++++++++++
 tb/tb_int_dispatch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/int_dispatch_queue.sv
// Integer dispatch queue: FIFO of renamed uops feeding the integer RS, with CDB snoop wakeup.
// Optional feature macro: DISPATCH_CDB_WAKEUP_EN (defined = wakeup on stored, enqueued and forwarded uops).
module int_dispatch_queue #(
   parameter int DEPTH     = 8,
   parameter int CDB_WIDTH = 2,
   parameter int PRF_IDX_W = 6,
   localparam int UOP_W    = 84 + 3 * PRF_IDX_W,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [UOP_W-1:0]               in_uop,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [UOP_W-1:0]               out_uop,
   input  logic [CDB_WIDTH-1:0]           cdb_valid,
   input  logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy,
   output logic [CNT_W-1:0]               count
);

   // uop layout, MSB..LSB: pc[32] fu_opcode[4] op1_sel[2] op2_sel[2] rd_phy rs1_phy rs2_phy
   // rs1_valid rs2_valid imm[32] rob_id[5] rd_arch[5]
   localparam int AW         = $clog2(DEPTH);
   localparam int RS2_V_BIT  = 42;
   localparam int RS1_V_BIT  = 43;
   localparam int RS2_PHY_LO = 44;
   localparam int RS1_PHY_LO = 44 + PRF_IDX_W;

   logic [UOP_W-1:0] mem_q [DEPTH];
   logic [UOP_W-1:0] mem_wk_s [DEPTH];
   logic [UOP_W-1:0] in_wk_s;
   logic [AW:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_s, empty_s, enq_s, deq_s;

   assign full_s    = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
   assign empty_s   = (head_q == tail_q);
   assign in_ready  = !full_s;
   assign out_valid = !empty_s;
   assign enq_s     = in_valid && !full_s && !flush;
   assign deq_s     = !empty_s && out_ready && !flush;
   assign count     = count_q;
   assign out_uop   = empty_s ? {UOP_W{1'b0}} : mem_wk_s[head_q[AW-1:0]];

`ifdef DISPATCH_CDB_WAKEUP_EN
   function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0] phy,
                                    input logic [CDB_WIDTH-1:0] v,
                                    input logic [CDB_WIDTH*PRF_IDX_W-1:0] idx);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         hit = hit | (v[k] && (idx[k*PRF_IDX_W +: PRF_IDX_W] == phy));
      end
      return hit && (phy != {PRF_IDX_W{1'b0}});
   endfunction

   function automatic logic [UOP_W-1:0] wake(input logic [UOP_W-1:0] uop,
                                             input logic [CDB_WIDTH-1:0] v,
                                             input logic [CDB_WIDTH*PRF_IDX_W-1:0] idx);
      logic [UOP_W-1:0] u;
      u = uop;
      u[RS1_V_BIT] = uop[RS1_V_BIT] | cdb_hit(uop[RS1_PHY_LO +: PRF_IDX_W], v, idx);
      u[RS2_V_BIT] = uop[RS2_V_BIT] | cdb_hit(uop[RS2_PHY_LO +: PRF_IDX_W], v, idx);
      return u;
   endfunction

   // The same woken view feeds storage next-state and the out_uop forward.
   always_comb begin
      in_wk_s = wake(in_uop, cdb_valid, cdb_rd_phy);
      for (int i = 0; i < DEPTH; i++) begin
         mem_wk_s[i] = wake(mem_q[i], cdb_valid, cdb_rd_phy);
      end
   end
`else
   logic unused_cdb_s;
   assign unused_cdb_s = ^{cdb_valid, cdb_rd_phy};

   always_comb begin
      in_wk_s = in_uop;
      for (int i = 0; i < DEPTH; i++) begin
         mem_wk_s[i] = mem_q[i];
      end
   end
`endif

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = {(AW+1){1'b0}};
         tail_d  = {(AW+1){1'b0}};
         count_d = {CNT_W{1'b0}};
      end else begin
         if (enq_s) tail_d = tail_q + {{AW{1'b0}}, 1'b1};
         else       tail_d = tail_q;
         if (deq_s) head_d = head_q + {{AW{1'b0}}, 1'b1};
         else       head_d = head_q;
         if (enq_s && !deq_s)      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         else if (deq_s && !enq_s) count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
         else                      count_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= {(AW+1){1'b0}};
         tail_q  <= {(AW+1){1'b0}};
         count_q <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= {UOP_W{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (enq_s && (tail_q[AW-1:0] == AW'(i))) mem_q[i] <= in_wk_s;
            else                                     mem_q[i] <= mem_wk_s[i];
         end
      end
   end

endmodule

// File: tb/tb_int_dispatch_queue.sv
// Directed self-checking bench for int_dispatch_queue (default parameters).
module tb_int_dispatch_queue;
   localparam int P = 6;
   localparam int UW = 84 + 3 * P;
`ifdef DISPATCH_CDB_WAKEUP_EN
   localparam logic WK = 1'b1;
`else
   localparam logic WK = 1'b0;
`endif

   logic          clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [UW-1:0] in_uop, out_uop;
   logic [1:0]    cdb_valid;
   logic [2*P-1:0] cdb_rd_phy;
   logic [3:0]    count;
   int            n_pass = 0;
   int            n_total = 0;

   int_dispatch_queue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
      .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
      .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [UW-1:0] mk(input logic [P-1:0] rd, input logic [P-1:0] rs1,
                                        input logic [P-1:0] rs2, input logic v1, input logic v2,
                                        input logic [31:0] imm, input logic [4:0] rob);
      return {32'h0000_1000 + 32'(rob) * 32'd4, 4'd1, 2'd0, 2'd1, rd, rs1, rs2, v1, v2, imm, rob, 5'd3};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_uop = '0; cdb_valid = 2'b00; cdb_rd_phy = '0;
      #3;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
      n_total++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
      n_total++; if (out_uop !== '0) $display("FAIL reset_out_uop got %0h want 0", out_uop); else n_pass++;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      logic [UW-1:0] u;
      u = mk(6'd1, 6'd2, 6'd0, 1'b1, 1'b0, 32'd1, 5'd0);
      in_valid = 1'b1; in_uop = u; out_ready = 1'b1;
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL single_no_bypass got %0b want 0", out_valid); else n_pass++;
      step();
      in_valid = 1'b0;
      n_total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %0b want 1", out_valid); else n_pass++;
      n_total++; if (out_uop !== u) $display("FAIL single_out_uop got %0h want %0h", out_uop, u); else n_pass++;
      n_total++; if (count !== 4'd1) $display("FAIL single_count1 got %0d want 1", count); else n_pass++;
      step();
      out_ready = 1'b0;
      n_total++; if (count !== 4'd0) $display("FAIL single_count0 got %0d want 0", count); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL single_empty got %0b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_uop = mk(6'd9, 6'd10, 6'd11, 1'b1, 1'b1, 32'(i), 5'(i));
         step();
      end
      n_total++; if (count !== 4'd8) $display("FAIL fill_count got %0d want 8", count); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %0b want 0", in_ready); else n_pass++;
      in_uop = mk(6'd9, 6'd10, 6'd11, 1'b1, 1'b1, 32'd8, 5'd8);
      step();
      in_valid = 1'b0;
      n_total++; if (count !== 4'd8) $display("FAIL ninth_count got %0d want 8", count); else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (out_uop[9:5] !== 5'(i) || out_valid !== 1'b1)
            $display("FAIL drain_order got rob %0d valid %0b want rob %0d valid 1", out_uop[9:5], out_valid, i);
         else n_pass++;
         step();
      end
      out_ready = 1'b0;
      n_total++; if (count !== 4'd0 || out_valid !== 1'b0) $display("FAIL drain_empty got count %0d valid %0b want 0 0", count, out_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_uop = mk(6'd9, 6'd10, 6'd11, 1'b1, 1'b1, 32'd0, 5'(16 + i));
         step();
      end
      in_uop = mk(6'd9, 6'd10, 6'd11, 1'b1, 1'b1, 32'd0, 5'd31);
      out_ready = 1'b1;
      #1;
      n_total++; if (in_ready !== 1'b0) $display("FAIL full_deq_in_ready_before got %0b want 0", in_ready); else n_pass++;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      n_total++; if (count !== 4'd7) $display("FAIL full_deq_count got %0d want 7", count); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL full_deq_in_ready got %0b want 1", in_ready); else n_pass++;
      n_total++; if (out_uop[9:5] !== 5'd17) $display("FAIL full_deq_head got rob %0d want 17", out_uop[9:5]); else n_pass++;
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_total++; if (count !== 4'd0) $display("FAIL full_flush_count got %0d want 0", count); else n_pass++;
   endtask

   task automatic test_wakeup();
      out_ready = 1'b0;
      in_valid = 1'b1; in_uop = mk(6'd4, 6'd3, 6'd5, 1'b1, 1'b0, 32'd0, 5'd3);
      step();
      in_valid = 1'b0;
      cdb_valid = 2'b10; cdb_rd_phy = {6'd5, 6'd0};
      #1;
      n_total++; if (out_uop[42] !== WK) $display("FAIL wk_stall_fwd got %0b want %0b", out_uop[42], WK); else n_pass++;
      step();
      cdb_valid = 2'b00; cdb_rd_phy = '0;
      #1;
      n_total++; if (out_uop[42] !== WK) $display("FAIL wk_stall_stored got %0b want %0b", out_uop[42], WK); else n_pass++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b1; in_uop = mk(6'd4, 6'd3, 6'd5, 1'b1, 1'b0, 32'd0, 5'd4);
      step();
      in_valid = 1'b0;
      n_total++; if (out_uop[42] !== 1'b0) $display("FAIL wk_pre_bcast got %0b want 0", out_uop[42]); else n_pass++;
      cdb_valid = 2'b01; cdb_rd_phy = {6'd0, 6'd5}; out_ready = 1'b1;
      #1;
      n_total++; if (out_uop[42] !== WK || out_valid !== 1'b1) $display("FAIL wk_deq_fwd got %0b want %0b", out_uop[42], WK); else n_pass++;
      step();
      cdb_valid = 2'b00; cdb_rd_phy = '0; out_ready = 1'b0;
      in_valid = 1'b1; in_uop = mk(6'd4, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 5'd5);
      step();
      in_valid = 1'b0;
      cdb_valid = 2'b11; cdb_rd_phy = '0;
      #1;
      n_total++; if (out_uop[43:42] !== 2'b00) $display("FAIL wk_idx0_fwd got %0b want 00", out_uop[43:42]); else n_pass++;
      step();
      n_total++; if (out_uop[43:42] !== 2'b00) $display("FAIL wk_idx0_stored got %0b want 00", out_uop[43:42]); else n_pass++;
      cdb_valid = 2'b00;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b1; in_uop = mk(6'd4, 6'd7, 6'd8, 1'b0, 1'b1, 32'd0, 5'd6);
      cdb_valid = 2'b01; cdb_rd_phy = {6'd0, 6'd7};
      step();
      in_valid = 1'b0; cdb_valid = 2'b00; cdb_rd_phy = '0;
      #1;
      n_total++; if (out_uop[43] !== WK) $display("FAIL wk_enq_path got %0b want %0b", out_uop[43], WK); else n_pass++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_total++; if (count !== 4'd0) $display("FAIL wk_end_count got %0d want 0", count); else n_pass++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_uop = mk(6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 32'd0, 5'(i));
         step();
      end
      in_uop = mk(6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 32'd0, 5'd9);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_total++; if (count !== 4'd0) $display("FAIL flush_count got %0d want 0", count); else n_pass++;
      n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_flags got valid %0b ready %0b want 0 1", out_valid, in_ready); else n_pass++;
      in_valid = 1'b1; in_uop = mk(6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 32'd0, 5'd10);
      step();
      in_valid = 1'b0;
      n_total++; if (out_uop[9:5] !== 5'd10 || count !== 4'd1) $display("FAIL flush_after got rob %0d count %0d want 10 1", out_uop[9:5], count); else n_pass++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_uop = mk(6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 32'd0, 5'(20 + i));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      n_total++; if (count !== 4'd3) $display("FAIL mid_pre_count got %0d want 3", count); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_total++; if (out_valid !== 1'b0 || count !== 4'd0) $display("FAIL mid_reset got valid %0b count %0d want 0 0", out_valid, count); else n_pass++;
      step();
      rst_n = 1'b1; out_ready = 1'b0;
      step();
      n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL post_reset got ready %0b valid %0b want 1 0", in_ready, out_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_wakeup();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
